// File: rtl/hpm_pkg.sv
// Shared definitions for the hardware performance monitor: CSR address map,
// mcountinhibit/mhpmevent bit positions, bus widths and the counter type.
package hpm_pkg;

    localparam int unsigned CSR_ADDR_WIDTH         = 12;
    localparam int unsigned REG_DATA_WIDTH         = 32;
    localparam int unsigned COMMIT_CSR_CHANNEL_NUM = 4;
    localparam int unsigned COMMIT_WIDTH           = 4;

    typedef logic [CSR_ADDR_WIDTH-1:0] csr_addr_t;
    typedef logic [63:0]               hpm_cnt_t;

    localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
    localparam csr_addr_t CSR_MHPMEVENT3    = 12'h323;
    localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
    localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
    localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
    localparam csr_addr_t CSR_MINSTRETH     = 12'hB82;
    localparam csr_addr_t CSR_MHPMCOUNTER3  = 12'hB03;
    localparam csr_addr_t CSR_MHPMCOUNTER3H = 12'hB83;

    localparam int unsigned HPM_OF_BIT       = 31;
    localparam int unsigned INHIBIT_CY_BIT   = 0;
    localparam int unsigned INHIBIT_IR_BIT   = 2;
    localparam int unsigned INHIBIT_HPM_BASE = 3;

    // Counter slot 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k)
    function automatic csr_addr_t cnt_addr_lo(input int unsigned idx);
        case (idx)
            0:       return CSR_MCYCLE;
            1:       return CSR_MINSTRET;
            default: return CSR_ADDR_WIDTH'(32'(CSR_MHPMCOUNTER3) + idx - 32'd2);
        endcase
    endfunction

    function automatic csr_addr_t cnt_addr_hi(input int unsigned idx);
        case (idx)
            0:       return CSR_MCYCLEH;
            1:       return CSR_MINSTRETH;
            default: return CSR_ADDR_WIDTH'(32'(CSR_MHPMCOUNTER3H) + idx - 32'd2);
        endcase
    endfunction

    function automatic csr_addr_t evt_addr(input int unsigned k);
        return CSR_ADDR_WIDTH'(32'(CSR_MHPMEVENT3) + k);
    endfunction

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// hpm_counter: one 64-bit performance counter with per-half CSR writes.
// Ports: clk, rst (sync active-low), inhibit, add (increment), we_lo/we_hi,
//        wdata_lo/wdata_hi, value (current count), carry_out (this cycle's
//        increment wraps past bit 63; combinational).
module hpm_counter
    import hpm_pkg::*;
#(
    parameter int unsigned ADD_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inhibit,
    input  logic [ADD_WIDTH-1:0] add,
    input  logic                 we_lo,
    input  logic                 we_hi,
    input  logic [31:0]          wdata_lo,
    input  logic [31:0]          wdata_hi,
    output hpm_cnt_t             value,
    output logic                 carry_out
);

    logic [64:0] sum;
    logic        count_en;

    // A CSR write to either half suppresses this cycle's increment
    always_comb begin
        count_en  = !inhibit && !we_lo && !we_hi;
        sum       = {1'b0, value} + 65'(add);
        carry_out = count_en && sum[64];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (we_lo || we_hi) begin
            value <= {(we_hi ? wdata_hi : value[63:32]),
                      (we_lo ? wdata_lo : value[31:0])};
        end else if (!inhibit) begin
            value <= sum[63:0];
        end
    end

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine-mode performance monitor: mcycle, minstret and NUM_HPM
// programmable counters with event select, inhibit and sticky overflow.
// Ports: clk, rst (sync active-low); per-channel CSR read address/data
//        (combinational read), write address/data/enable; event_add
//        increments; commit_hpm_instret_add; mcountinhibit and mcycle
//        snapshots; hpm_overflow_irq (registered OR of all OF bits).
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int unsigned NUM_HPM           = 4,
    parameter int unsigned EVENT_NUM         = 16,
    parameter int unsigned EVENT_ADD_WIDTH   = 3,
    parameter int unsigned CHANNEL_NUM       = COMMIT_CSR_CHANNEL_NUM,
    parameter int unsigned INSTRET_ADD_WIDTH = $clog2(COMMIT_WIDTH) + 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [CHANNEL_NUM-1:0][CSR_ADDR_WIDTH-1:0]       commit_hpm_read_addr,
    output logic [CHANNEL_NUM-1:0][REG_DATA_WIDTH-1:0]       hpm_commit_read_data,
    input  logic [CHANNEL_NUM-1:0][CSR_ADDR_WIDTH-1:0]       commit_hpm_write_addr,
    input  logic [CHANNEL_NUM-1:0][REG_DATA_WIDTH-1:0]       commit_hpm_write_data,
    input  logic [CHANNEL_NUM-1:0]                           commit_hpm_we,
    input  logic [EVENT_NUM-1:0][EVENT_ADD_WIDTH-1:0]        event_add,
    input  logic [INSTRET_ADD_WIDTH-1:0]                     commit_hpm_instret_add,
    output logic [31:0]                                      hpm_all_mcountinhibit_data,
    output logic [63:0]                                      hpm_all_mcycle_data,
    output logic                                             hpm_overflow_irq
);

    localparam int unsigned SEL_W   = $clog2(EVENT_NUM);
    localparam int unsigned NUM_CNT = NUM_HPM + 2;
    localparam logic [31:0] INHIBIT_MASK =
        32'(((64'd1 << NUM_HPM) - 64'd1) << INHIBIT_HPM_BASE) |
        (32'd1 << INHIBIT_CY_BIT) | (32'd1 << INHIBIT_IR_BIT);

    logic [31:0]                  inhibit_q;
    logic [NUM_HPM-1:0]           of_q;
    logic [NUM_HPM-1:0][SEL_W-1:0] sel_q;
    logic                         irq_q;

    hpm_cnt_t                     cnt_value [NUM_CNT];
    logic [NUM_CNT-1:0]           cnt_we_lo, cnt_we_hi;
    logic [NUM_CNT-1:0][31:0]     cnt_wd_lo, cnt_wd_hi;
    logic [NUM_HPM-1:0]           hpm_carry;
    logic [1:0]                   unused_carry;

    logic                         inhibit_we;
    logic [31:0]                  inhibit_wd;
    logic [NUM_HPM-1:0]           evt_we;
    logic [NUM_HPM-1:0]           evt_wd_of;
    logic [NUM_HPM-1:0][SEL_W-1:0] evt_wd_sel;
    logic [SEL_W-1:0]             wsel;

    // Write decode; ascending channel scan lets the highest channel win
    always_comb begin
        inhibit_we = 1'b0;
        inhibit_wd = '0;
        evt_we     = '0;
        evt_wd_of  = '0;
        evt_wd_sel = '0;
        cnt_we_lo  = '0;
        cnt_we_hi  = '0;
        cnt_wd_lo  = '0;
        cnt_wd_hi  = '0;
        wsel       = '0;
        for (int unsigned ch = 0; ch < CHANNEL_NUM; ch++) begin
            if (commit_hpm_we[ch]) begin
                if (commit_hpm_write_addr[ch] == CSR_MCOUNTINHIBIT) begin
                    inhibit_we = 1'b1;
                    inhibit_wd = commit_hpm_write_data[ch];
                end
                for (int unsigned k = 0; k < NUM_HPM; k++) begin
                    if (commit_hpm_write_addr[ch] == evt_addr(k)) begin
                        wsel          = commit_hpm_write_data[ch][SEL_W-1:0];
                        evt_we[k]     = 1'b1;
                        evt_wd_of[k]  = commit_hpm_write_data[ch][HPM_OF_BIT];
                        // Out-of-range selectors fall back to "no event"
                        evt_wd_sel[k] = (32'(wsel) < EVENT_NUM) ? wsel : '0;
                    end
                end
                for (int unsigned i = 0; i < NUM_CNT; i++) begin
                    if (commit_hpm_write_addr[ch] == cnt_addr_lo(i)) begin
                        cnt_we_lo[i] = 1'b1;
                        cnt_wd_lo[i] = commit_hpm_write_data[ch];
                    end
                    if (commit_hpm_write_addr[ch] == cnt_addr_hi(i)) begin
                        cnt_we_hi[i] = 1'b1;
                        cnt_wd_hi[i] = commit_hpm_write_data[ch];
                    end
                end
            end
        end
    end

    // Read mux: pre-cycle state, no write/increment bypass
    always_comb begin
        hpm_commit_read_data = '0;
        for (int unsigned ch = 0; ch < CHANNEL_NUM; ch++) begin
            if (commit_hpm_read_addr[ch] == CSR_MCOUNTINHIBIT) begin
                hpm_commit_read_data[ch] = inhibit_q;
            end
            for (int unsigned k = 0; k < NUM_HPM; k++) begin
                if (commit_hpm_read_addr[ch] == evt_addr(k)) begin
                    hpm_commit_read_data[ch] = (32'(of_q[k]) << HPM_OF_BIT) | 32'(sel_q[k]);
                end
            end
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (commit_hpm_read_addr[ch] == cnt_addr_lo(i)) begin
                    hpm_commit_read_data[ch] = cnt_value[i][31:0];
                end
                if (commit_hpm_read_addr[ch] == cnt_addr_hi(i)) begin
                    hpm_commit_read_data[ch] = cnt_value[i][63:32];
                end
            end
        end
    end

    hpm_counter #(.ADD_WIDTH(1)) u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .inhibit   (inhibit_q[INHIBIT_CY_BIT]),
        .add       (1'b1),
        .we_lo     (cnt_we_lo[0]),
        .we_hi     (cnt_we_hi[0]),
        .wdata_lo  (cnt_wd_lo[0]),
        .wdata_hi  (cnt_wd_hi[0]),
        .value     (cnt_value[0]),
        .carry_out (unused_carry[0])
    );

    hpm_counter #(.ADD_WIDTH(INSTRET_ADD_WIDTH)) u_minstret (
        .clk       (clk),
        .rst       (rst),
        .inhibit   (inhibit_q[INHIBIT_IR_BIT]),
        .add       (commit_hpm_instret_add),
        .we_lo     (cnt_we_lo[1]),
        .we_hi     (cnt_we_hi[1]),
        .wdata_lo  (cnt_wd_lo[1]),
        .wdata_hi  (cnt_wd_hi[1]),
        .value     (cnt_value[1]),
        .carry_out (unused_carry[1])
    );

    // Selector 0 means "no event": treated as inhibited
    for (genvar gk = 0; gk < NUM_HPM; gk++) begin : g_hpm
        hpm_counter #(.ADD_WIDTH(EVENT_ADD_WIDTH)) u_hpm (
            .clk       (clk),
            .rst       (rst),
            .inhibit   (inhibit_q[INHIBIT_HPM_BASE + gk] || (sel_q[gk] == '0)),
            .add       (event_add[sel_q[gk]]),
            .we_lo     (cnt_we_lo[gk + 2]),
            .we_hi     (cnt_we_hi[gk + 2]),
            .wdata_lo  (cnt_wd_lo[gk + 2]),
            .wdata_hi  (cnt_wd_hi[gk + 2]),
            .value     (cnt_value[gk + 2]),
            .carry_out (hpm_carry[gk])
        );
    end

    // Control registers; hardware overflow set wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            inhibit_q <= '0;
            of_q      <= '0;
            sel_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (inhibit_we) begin
                inhibit_q <= inhibit_wd & INHIBIT_MASK;
            end
            for (int unsigned k = 0; k < NUM_HPM; k++) begin
                of_q[k] <= (evt_we[k] ? evt_wd_of[k] : of_q[k]) | hpm_carry[k];
                if (evt_we[k]) begin
                    sel_q[k] <= evt_wd_sel[k];
                end
            end
            irq_q <= |of_q;
        end
    end

    assign hpm_all_mcountinhibit_data = inhibit_q;
    assign hpm_all_mcycle_data        = cnt_value[0];
    assign hpm_overflow_irq           = irq_q;

endmodule

// File: doc/hpm_counter_bank.md
Name: hpm_counter_bank

Overview:
Parametrised machine-mode hardware performance monitor. It is the successor to the fixed perf-counter fields inside csrfile. It provides 64-bit mcycle, minstret and NUM_HPM programmable mhpmcounterN, each with:
- an event selector (mhpmevent), which picks one of EVENT_NUM multi-bit event increments;
- an inhibit bit (mcountinhibit);
- a sticky overflow flag that drives an interrupt request.
It sits beside csrfile and is accessed through the same CHANNEL_NUM commit CSR read/write channels.

Parameters:
NUM_HPM, 4, number of programmable counters mhpmcounter3..3+NUM_HPM-1 (1..29)
EVENT_NUM, 16, number of event inputs; event index 0 is reserved as "no event"
EVENT_ADD_WIDTH, 3, width of each per-cycle event increment
CHANNEL_NUM, `COMMIT_CSR_CHANNEL_NUM, number of commit read/write channels
INSTRET_ADD_WIDTH, $clog2(`COMMIT_WIDTH)+1, width of the retired-instruction increment

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
commit_hpm_read_addr  in  [CHANNEL_NUM][`CSR_ADDR_WIDTH]  read address per channel
hpm_commit_read_data  out  [CHANNEL_NUM][`REG_DATA_WIDTH]  read data per channel, combinational
commit_hpm_write_addr  in  [CHANNEL_NUM][`CSR_ADDR_WIDTH]  write address per channel
commit_hpm_write_data  in  [CHANNEL_NUM][`REG_DATA_WIDTH]  write data per channel
commit_hpm_we  in  [CHANNEL_NUM]  write enable per channel
event_add  in  [EVENT_NUM][EVENT_ADD_WIDTH]  per-event increment this cycle; entry 0 is ignored
commit_hpm_instret_add  in  INSTRET_ADD_WIDTH  instructions retired this cycle
hpm_all_mcountinhibit_data  out  32  current mcountinhibit
hpm_all_mcycle_data  out  64  current mcycle
hpm_overflow_irq  out  1  OR of all mhpmevent OF bits

Behaviour:
- Address map:
  - mcountinhibit 0x320.
  - mhpmevent3+k at 0x323+k.
  - mcycle 0xB00 / mcycleh 0xB80; minstret 0xB02 / minstreth 0xB82.
  - mhpmcounter3+k at 0xB03+k / 0xB83+k.
  - Any other address reads 0; writes to it are ignored.
- Reset (rst=0 at posedge): all counters = 0, mcountinhibit = 0, all mhpmevent = 0. Consequently hpm_overflow_irq = 0 and both all-data outputs = 0. Reset overrides any same-cycle write or increment.
- Reads:
  - Combinational, zero latency, independent per channel.
  - Reads return register state before this cycle's writes and increments; there is no bypass.
- Writes: registered; visible one cycle later. If several channels write the same address in one cycle, the highest channel index wins.
- mcountinhibit:
  - Writable mask: bit0 (CY), bit2 (IR), bits 3..3+NUM_HPM-1.
  - Bit1 and all bits above the mask read 0.
- mhpmevent:
  - Bit 31 = OF; bits [$clog2(EVENT_NUM)-1:0] = event select; all other bits read 0.
  - An event select >= EVENT_NUM is stored as 0.
- Counter update each cycle, when not in reset:
  - mcycle += 1 unless CY is set.
  - minstret += commit_hpm_instret_add unless IR is set.
  - mhpmcounterN += event_add[sel] unless its inhibit bit is set or sel == 0.
  - All increments are zero-extended to 64 bits; counters wrap modulo 2^64.
- CSR write vs. increment:
  - A CSR write to either half of a counter replaces that 32-bit half. The other half is kept at its pre-cycle value. No increment is applied to that counter in that cycle.
  - Lo and hi halves written in the same cycle (same or different channels) are both applied, with no increment.
- Overflow:
  - When an mhpmcounter increment carries out of bit 63, the OF bit of its mhpmevent is set next cycle.
  - If software writes that mhpmevent in the same cycle, new OF = written bit31 OR overflow, i.e. hardware set wins.
  - OF is sticky until software clears it.
  - mcycle and minstret have no OF bit.
- hpm_overflow_irq: registered OR of all OF bits; asserts the cycle after OF is set.

Decomposition:
- hpm_pkg holds:
  - CSR address localparams;
  - HPM_OF_BIT = 31;
  - the mcountinhibit bit positions;
  - a typedef for the 64-bit counter.
- One sub-module, hpm_counter: 64-bit counter with inputs inhibit, add value, we_lo/we_hi and write data; outputs value and carry_out. It is instantiated NUM_HPM+2 times; carry_out is unused for mcycle and minstret.

Test Plan:
- Reset: rst=0 for 2 cycles with writes active -> all reads 0 and irq=0. Release, hold CY clear -> mcycle reads 1, 2, 3 on successive cycles.
- Event counting: write mhpmevent3=5, then drive event_add[5]=3 for 4 cycles with inhibit clear -> mhpmcounter3 reads 12. Set inhibit bit3 -> the value holds at 12.
- Write priority: channel 0 writes 0xB03=0x11 and channel 3 writes 0xB03=0x22 in the same cycle, with event active -> next cycle reads 0x22 exactly (no increment).
- Wrap and overflow: write 0xB03=0xFFFFFFFF and 0xB83=0xFFFFFFFF, then event_add=2 -> counter reads 1, OF=1 the next cycle, irq=1 one cycle after. Write mhpmevent3 with bit31=0 -> OF clears and irq deasserts.
- Same-cycle OF clear vs. overflow: clear OF while the counter wraps in that cycle -> OF reads 1 and irq stays 1.
- mcountinhibit mask: write 0xFFFFFFFF with NUM_HPM=4 -> reads 0x0000007D. Unmapped address 0x7C0 reads 0.
